nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nsa_pkg.sv | 18 +
 rtl/nibble_serial_adder_if.sv | 44 ++++
 rtl/nibble_serial_adder_rca4.sv | 21 ++
 rtl/nibble_serial_adder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, digit width
// and the index-counter width helper.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

  // Index counter width: ceil(log2(n)), never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The ovf signal exists only when NSA_OVERFLOW_EN is defined.
interface nibble_serial_adder_if
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) ();

  localparam int W = NIBBLES * NIBBLE_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NSA_OVERFLOW_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/nibble_serial_adder_rca4.sv
// Purely combinational 4-bit ripple-carry adder made of four full-adder cells.
module rca4_core (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit digit per cycle through a single rca4_core.
// Define NSA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int                W        = NIBBLES * NIBBLE_W;
  localparam int                IDX_W    = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  nsa_state_e       state_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     sum_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [3:0]       x_s;
  logic [3:0]       y_s;
  logic [3:0]       s_s;
  logic             co_s;
  logic [W-1:0]     sum_nxt_s;

  // Select the operand digits addressed by the current index.
  always_comb begin
    x_s = 4'h0;
    y_s = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      x_s = x_s | (a_r[i*NIBBLE_W +: NIBBLE_W] & {NIBBLE_W{idx_r == IDX_W'(i)}});
      y_s = y_s | (b_r[i*NIBBLE_W +: NIBBLE_W] & {NIBBLE_W{idx_r == IDX_W'(i)}});
    end
  end

  rca4_core u_rca4 (
    .x  (x_s),
    .y  (y_s),
    .ci (carry_r),
    .s  (s_s),
    .co (co_s)
  );

  // Merge the new digit into the running sum at the current index.
  always_comb begin
    sum_nxt_s = sum_r;
    for (int i = 0; i < NIBBLES; i++) begin
      sum_nxt_s[i*NIBBLE_W +: NIBBLE_W] =
        (idx_r == IDX_W'(i)) ? s_s : sum_r[i*NIBBLE_W +: NIBBLE_W];
    end
  end

`ifdef NSA_OVERFLOW_EN
  logic ovf_r;
  logic ovf_nxt_s;

  // Carry into the top bit is recovered from its sum bit: c3 = s3 ^ x3 ^ y3.
  always_comb begin
    ovf_nxt_s = s_s[3] ^ x_s[3] ^ y_s[3] ^ co_s;
  end
`endif

  // Control FSM with registered handshake flags and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            carry_r    <= bus.cin;
            idx_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            state_r    <= IDLE;
          end
        end
        RUN: begin
          sum_r   <= sum_nxt_s;
          carry_r <= co_s;
          // Index parks on the last digit so it never wraps mid-operation.
          if (idx_r == LAST_IDX) begin
            cout_r      <= co_s;
`ifdef NSA_OVERFLOW_EN
            ovf_r       <= ovf_nxt_s;
`endif
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r       <= idx_r + IDX_ONE;
          end
        end
        DONE: begin
          // Release to IDLE only; a new accept needs a fresh IDLE cycle.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
`ifdef NSA_OVERFLOW_EN
  assign bus.ovf       = ovf_r;
`endif

endmodule
